// File: rtl/pix_pack_pkg.sv
// Shared types and default geometry for the 16-to-128 pixel packer.
package pix_pack_pkg;

  localparam int IN_WIDTH  = 16;
  localparam int OUT_WIDTH = 128;
  localparam int RATIO     = 8;
  localparam int LANE_W    = $clog2(RATIO);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/pix_pack_16to128.sv
// Packs IN_WIDTH-bit pixels LSB-first into OUT_WIDTH-bit FIFO words, stalling in HOLD on wr_full.
// Optional line-end zero-padded flush is enabled with `define PIX_PACK_LINE_FLUSH_EN.
module pix_pack_16to128 #(
  parameter int IN_WIDTH  = pix_pack_pkg::IN_WIDTH,
  parameter int OUT_WIDTH = pix_pack_pkg::OUT_WIDTH,
  parameter int RATIO     = pix_pack_pkg::RATIO
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_vsync,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic [OUT_WIDTH-1:0] wr_data,
  input  logic                 wr_full,
  output logic [15:0]          frame_words,
  output logic                 align_err
);
  import pix_pack_pkg::*;

  localparam int            LW        = $clog2(RATIO);
  localparam logic [LW-1:0] LANE_LAST = LW'(RATIO - 1);

  state_e                 state_reg, state_next;
  logic [LW-1:0]          lane_reg, lane_next, lane_eff;
  logic [OUT_WIDTH-1:0]   acc_reg, acc_next, word_next;
  logic [OUT_WIDTH-1:0]   wr_data_reg;
  logic                   wr_en_reg, wr_en_next;
  logic [15:0]            frame_words_reg;
  logic                   align_err_reg;
  logic                   in_ready_c, accept, flush, complete;

  // A frame start realigns before the same-cycle pixel is placed, so it lands in lane 0.
  assign lane_eff = in_vsync ? '0 : lane_reg;
  assign accept   = in_valid && in_ready_c;

`ifdef PIX_PACK_LINE_FLUSH_EN
  assign flush = accept && in_last && (lane_eff != LANE_LAST);
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign flush          = 1'b0;
`endif

  assign complete = accept && ((lane_eff == LANE_LAST) || flush);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ACCUM;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACCUM:   if (complete && wr_full) state_next = HOLD;
      HOLD:    if (!wr_full)            state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready_c = 1'b0;
    wr_en_next = 1'b0;
    case (state_reg)
      ACCUM: begin
        in_ready_c = 1'b1;
        wr_en_next = complete && !wr_full;
      end
      HOLD:    wr_en_next = !wr_full;
      default: ;
    endcase
  end

  // Lane insert; untouched upper lanes stay zero because the accumulator clears per word.
  always_comb begin
    word_next = in_vsync ? '0 : acc_reg;
    if (accept) word_next[int'(lane_eff) * IN_WIDTH +: IN_WIDTH] = in_data;
    acc_next  = complete ? '0 : word_next;
    lane_next = complete ? '0 : (accept ? lane_eff + LW'(1) : lane_eff);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_reg        <= '0;
      acc_reg         <= '0;
      wr_data_reg     <= '0;
      wr_en_reg       <= 1'b0;
      frame_words_reg <= '0;
      align_err_reg   <= 1'b0;
    end else begin
      lane_reg  <= lane_next;
      acc_reg   <= acc_next;
      wr_en_reg <= wr_en_next;
      // complete only fires in ACCUM, so a word parked in HOLD is never overwritten
      if (complete) wr_data_reg <= word_next;
      if (in_vsync)
        frame_words_reg <= '0;
      else if (wr_en_reg && (frame_words_reg != 16'hFFFF))
        frame_words_reg <= frame_words_reg + 16'd1;
      if (in_vsync && (lane_reg != '0)) align_err_reg <= 1'b1;
    end
  end

  assign in_ready    = in_ready_c;
  assign wr_en       = wr_en_reg;
  assign wr_data     = wr_data_reg;
  assign frame_words = frame_words_reg;
  assign align_err   = align_err_reg;

endmodule

// File: tb/tb_pix_pack_16to128.sv
// Scoreboard bench for pix_pack_16to128: stimulus pushes expected words, a monitor pops on wr_en.
module tb_pix_pack_16to128;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_vsync, in_valid, in_last, in_ready;
  logic [15:0]  in_data;
  logic         wr_en, wr_full;
  logic [127:0] wr_data;
  logic [15:0]  frame_words;
  logic         align_err;

  int           pass_cnt = 0;
  int           chk_cnt  = 0;
  int           cyc      = 0;
  logic [127:0] exp_q[$];
  int           wr_cycles[$];

  pix_pack_16to128 dut (
    .clk(clk), .rst_n(rst_n), .in_vsync(in_vsync), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
    .frame_words(frame_words), .align_err(align_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every write is compared against the oldest expected word.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      logic [127:0] e;
      wr_cycles.push_back(cyc);
      chk("wr_en_while_full", {127'd0, wr_full}, 128'd0);
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_write: got %h expected no write", wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_data", wr_data, e);
        $display("write at cycle %0d: data %h", cyc, wr_data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [15:0] d, input logic last, input logic vs);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = last; in_vsync = vs;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
      in_vsync = 1'b0;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!done) begin
      chk_cnt++;
      $display("FAIL send_timeout: pixel %h got no in_ready expected accept", d);
    end
  endtask

  task automatic pulse_vsync();
    in_vsync = 1'b1;
    tick(1);
    in_vsync = 1'b0;
  endtask

  initial begin
    int t0, tdrop, c0, c1;
    rst_n = 1'b0; in_vsync = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = '0; wr_full = 1'b0;
    tick(2);
    @(negedge clk);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_wr_en", {127'd0, wr_en}, 128'd0);
    chk("rst_wr_data", wr_data, 128'd0);
    chk("rst_frame_words", {112'd0, frame_words}, 128'd0);
    chk("rst_align_err", {127'd0, align_err}, 128'd0);
    rst_n = 1'b1;
    tick(1);

    // 16 back-to-back pixels, no back-pressure
    t0 = cyc;
    wr_cycles.delete();
    exp_q.push_back(128'h0008_0007_0006_0005_0004_0003_0002_0001);
    exp_q.push_back(128'h0010_000f_000e_000d_000c_000b_000a_0009);
    for (int i = 1; i <= 16; i++) send(16'(i), 1'b0, 1'b0);
    tick(3);
    c0 = (wr_cycles.size() > 0) ? wr_cycles[0] - t0 + 1 : -1;
    c1 = (wr_cycles.size() > 1) ? wr_cycles[1] - t0 + 1 : -1;
    chk("first_write_cycle", 128'(c0), 128'd9);
    chk("second_write_cycle", 128'(c1), 128'd17);
    @(negedge clk);
    chk("frame_words_two", {112'd0, frame_words}, 128'd2);
    tick(1);

    // wr_full held for 5 cycles starting with the completing pixel
    exp_q.push_back(128'h0108_0107_0106_0105_0104_0103_0102_0101);
    for (int i = 1; i <= 7; i++) send(16'h0100 + 16'(i), 1'b0, 1'b0);
    wr_full = 1'b1;
    send(16'h0108, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_in_ready", {127'd0, in_ready}, 128'd0);
      @(posedge clk); #1;
    end
    wr_full = 1'b0;
    tdrop   = cyc;
    wr_cycles.delete();
    tick(2);
    c0 = (wr_cycles.size() > 0) ? wr_cycles[0] : -1;
    chk("hold_release_cycle", 128'(c0), 128'(tdrop + 1));
    @(negedge clk);
    chk("hold_exit_in_ready", {127'd0, in_ready}, 128'd1);
    chk("frame_words_three", {112'd0, frame_words}, 128'd3);
    tick(1);

    // in_last on the third pixel
`ifdef PIX_PACK_LINE_FLUSH_EN
    exp_q.push_back(128'h0000_0000_0000_0000_0000_cccc_bbbb_aaaa);
    exp_q.push_back(128'h0e08_0e07_0e06_0e05_0e04_0e03_0e02_0e01);
    send(16'haaaa, 1'b0, 1'b0);
    send(16'hbbbb, 1'b0, 1'b0);
    send(16'hcccc, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) send(16'h0e00 + 16'(i), 1'b0, 1'b0);
`else
    exp_q.push_back(128'h0d05_0d04_0d03_0d02_0d01_cccc_bbbb_aaaa);
    send(16'haaaa, 1'b0, 1'b0);
    send(16'hbbbb, 1'b0, 1'b0);
    send(16'hcccc, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) send(16'h0d00 + 16'(i), 1'b0, 1'b0);
`endif
    tick(3);
    @(negedge clk);
    chk("align_err_clean", {127'd0, align_err}, 128'd0);
    tick(1);

    // in_vsync after a partial word of 4 pixels
    for (int i = 1; i <= 4; i++) send(16'h0f00 + 16'(i), 1'b0, 1'b0);
    pulse_vsync();
    @(negedge clk);
    chk("vsync_align_err", {127'd0, align_err}, 128'd1);
    chk("vsync_frame_words", {112'd0, frame_words}, 128'd0);
    tick(1);
    exp_q.push_back(128'h2008_2007_2006_2005_2004_2003_2002_2001);
    for (int i = 1; i <= 8; i++) send(16'h2000 + 16'(i), 1'b0, 1'b0);
    tick(3);
    @(negedge clk);
    chk("frame_words_after_realign", {112'd0, frame_words}, 128'd1);
    tick(1);

    // in_vsync with a pending pixel while a word is held
    exp_q.push_back(128'h3008_3007_3006_3005_3004_3003_3002_3001);
    exp_q.push_back(128'h123b_123a_1239_1238_1237_1236_1235_1234);
    for (int i = 1; i <= 7; i++) send(16'h3000 + 16'(i), 1'b0, 1'b0);
    wr_full = 1'b1;
    send(16'h3008, 1'b0, 1'b0);
    fork
      send(16'h1234, 1'b0, 1'b1);
      begin tick(3); wr_full = 1'b0; end
    join
    for (int i = 1; i <= 7; i++) send(16'h1234 + 16'(i), 1'b0, 1'b0);
    tick(3);
    @(negedge clk);
    chk("frame_words_hold_vsync", {112'd0, frame_words}, 128'd2);
    chk("hold_vsync_in_ready", {127'd0, in_ready}, 128'd1);
    tick(1);

    // Reset while a write is on the port: outputs must drop without waiting for a clock
    for (int i = 1; i <= 8; i++) send(16'h5000 + 16'(i), 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_wr_en", {127'd0, wr_en}, 128'd0);
    chk("async_rst_wr_data", wr_data, 128'd0);
    chk("async_rst_frame_words", {112'd0, frame_words}, 128'd0);
    chk("async_rst_align_err", {127'd0, align_err}, 128'd0);
    chk("async_rst_in_ready", {127'd0, in_ready}, 128'd1);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Reset mid-word: the partial word must not leak into the next one
    for (int i = 1; i <= 3; i++) send(16'h4000 + 16'(i), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    exp_q.push_back(128'h6008_6007_6006_6005_6004_6003_6002_6001);
    for (int i = 1; i <= 8; i++) send(16'h6000 + 16'(i), 1'b0, 1'b0);
    tick(4);

    chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
